seq_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU. It executes the base integer ops plus SLT/SLTU and the RV32M multiply/divide family. Base ops complete in one cycle. MUL*/DIV*/REM* run iteratively, one bit per cycle. It sits between the decode/operand stage and writeback; the core stalls on ready_o/valid_o.

---
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 tb/tb_seq_alu.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result handshake bundle for seq_alu.
//   Request side : valid_i, ready_o, op_i[4:0], a_i, b_i
//   Result side  : valid_o, ready_i, result_o, zero_o, negative_o, err_o
//   Status       : busy_o (iterative operation in flight)
// master = requester/consumer (decode + writeback), slave = the ALU.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [4:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            negative_o;
  logic            err_o;
  logic            busy_o;

  modport master (
    output valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, negative_o, err_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, negative_o, err_o, busy_o
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Base ops, SLT/SLTU, divide-by-zero and signed
// overflow divides finish in one cycle; other MUL*/DIV*/REM* ops iterate one
// bit per cycle on operand magnitudes, then apply sign correction.
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  asynchronous active-high reset
//   bus    seq_alu_if.slave: request (valid_i/ready_o/op_i/a_i/b_i),
//          result (valid_o/ready_i/result_o/zero_o/negative_o/err_o), busy_o
module seq_alu #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input logic      clk_i,
  input logic      rst_i,
  seq_alu_if.slave bus
);
  localparam int              SHW      = $clog2(XLEN);
  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t          state_q, state_d;
  logic [SHW:0]    count_q;
  logic [XLEN-1:0] result_q;
  logic            err_q;
  logic            ready, accept;

  // Iteration datapath: hi = partial product / remainder, lo = multiplier /
  // quotient, opnd = multiplicand / divisor magnitude.
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic            mdiv_q, take_hi_q, neg_q;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [SHW-1:0]  shamt;
  logic            a_neg, b_neg, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res, imm_res;
  logic            imm_err, start_iter;
  logic [XLEN-1:0] init_lo, init_opnd;
  logic            init_neg, init_take_hi;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   hi_n, lo_n, fin_res, sel;
  logic [2*XLEN-1:0] prod, prod_adj;

  assign a_s      = bus.a_i;
  assign b_s      = bus.b_i;
  assign shamt    = bus.b_i[SHW-1:0];
  assign a_neg    = bus.a_i[XLEN-1];
  assign b_neg    = bus.b_i[XLEN-1];
  assign div_zero = (bus.b_i == '0);
  assign div_ovf  = (bus.a_i == MOST_NEG) && (bus.b_i == '1);
  // Signed divides (op[0]=0) also take the fast path on overflow.
  assign fast     = (bus.op_i[4:2] == 3'b101) && (div_zero || (div_ovf && !bus.op_i[0]));
  assign fast_res = div_zero ? (bus.op_i[1] ? bus.a_i : '1)
                             : (bus.op_i[1] ? '0 : bus.a_i);

  // Stage 0: decode the request, single-cycle results and iteration setup
  always_comb begin
    imm_res    = '0;
    imm_err    = 1'b0;
    start_iter = 1'b0;
    if (bus.op_i[2]) begin
      sgn_a = ~bus.op_i[0];
      sgn_b = ~bus.op_i[0];
    end else begin
      sgn_a = (bus.op_i[1:0] == 2'b01) || (bus.op_i[1:0] == 2'b10);
      sgn_b = (bus.op_i[1:0] == 2'b01);
    end
    neg_a        = sgn_a & a_neg;
    neg_b        = sgn_b & b_neg;
    init_take_hi = bus.op_i[2] ? bus.op_i[1] : (bus.op_i[1:0] != 2'b00);
    // Remainder follows the dividend; quotient/product follow sign mismatch.
    init_neg     = (bus.op_i[2] && bus.op_i[1]) ? neg_a : (neg_a ^ neg_b);
    init_lo      = bus.op_i[2] ? mag(bus.a_i, neg_a) : mag(bus.b_i, neg_b);
    init_opnd    = bus.op_i[2] ? mag(bus.b_i, neg_b) : mag(bus.a_i, neg_a);
    case (bus.op_i)
      5'b00000: imm_res = bus.a_i & bus.b_i;
      5'b00001: imm_res = bus.a_i | bus.b_i;
      5'b00010: imm_res = bus.a_i + bus.b_i;
      5'b00110: imm_res = bus.a_i - bus.b_i;
      5'b00011: imm_res = bus.a_i ^ bus.b_i;
      5'b00100: imm_res = bus.a_i << shamt;
      5'b00101: imm_res = bus.a_i >> shamt;
      5'b00111: imm_res = a_s >>> shamt;
      5'b01000: imm_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      5'b01001: imm_res = {{(XLEN-1){1'b0}}, (bus.a_i < bus.b_i)};
      5'b10000, 5'b10001, 5'b10010, 5'b10011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        if (!EN_MULDIV)  imm_err    = 1'b1;
        else if (fast)   imm_res    = fast_res;
        else             start_iter = 1'b1;
      end
      default: imm_err = 1'b1;
    endcase
  end

  // Stage 1: one shift-add / restoring shift-subtract step, plus sign fix-up
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (mdiv_q) begin
      if (!div_diff[XLEN]) begin
        hi_n = div_diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = div_shift[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_adj = neg_q ? -prod : prod;
    sel      = take_hi_q ? hi_n : lo_n;
    if (mdiv_q) fin_res = neg_q ? -sel : sel;
    else        fin_res = take_hi_q ? prod_adj[2*XLEN-1:XLEN] : prod_adj[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      ITER: if (count_q == CNT_ONE) state_d = DONE;
      DONE: begin
        ready = bus.ready_i;
        if (bus.ready_i && !bus.valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.valid_i && ready) state_d = start_iter ? ITER : DONE;
  end

  assign accept = bus.valid_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && start_iter) begin
        count_q <= CNT_INIT;
        err_q   <= 1'b0;
      end else if (accept) begin
        result_q <= imm_res;
        err_q    <= imm_err;
      end else if (state_q == ITER) begin
        count_q <= count_q - CNT_ONE;
        if (count_q == CNT_ONE) result_q <= fin_res;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && start_iter) begin
      hi_q      <= '0;
      lo_q      <= init_lo;
      opnd_q    <= init_opnd;
      mdiv_q    <= bus.op_i[2];
      take_hi_q <= init_take_hi;
      neg_q     <= init_neg;
    end else if (state_q == ITER) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = (state_q == DONE);
  assign bus.busy_o     = (state_q == ITER);
  assign bus.result_o   = result_q;
  assign bus.err_o      = err_q;
  assign bus.zero_o     = (result_q == '0);
  assign bus.negative_o = result_q[XLEN-1];
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: bench for seq_alu (XLEN=32). One instance with M ops enabled,
// one with EN_MULDIV=0. Directed vector table, hand-written backpressure and
// async-reset sequences, then random ops against a 64-bit arithmetic model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.XLEN(32)) bus ();
  seq_alu_if #(.XLEN(32)) bus2 ();

  seq_alu #(.XLEN(32), .EN_MULDIV(1'b1)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  seq_alu #(.XLEN(32), .EN_MULDIV(1'b0)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the op definitions.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; e = 1'b0; lat = 1;
    case (op)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2:  r = a + b;
      5'd6:  r = a - b;
      5'd3:  r = a ^ b;
      5'd4:  r = a << b[4:0];
      5'd5:  r = a >> b[4:0];
      5'd7:  r = 32'(sa >>> b[4:0]);
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      5'd16: begin p = sa * sb;           r = p[31:0];  lat = 33; end
      5'd17: begin p = sa * sb;           r = p[63:32]; lat = 33; end
      5'd18: begin p = sa * longint'(ub); r = p[63:32]; lat = 33; end
      5'd19: begin p = ua * ub;           r = p[63:32]; lat = 33; end
      5'd20: if (b == 0) r = '1; else if (ovf) r = a; else begin r = 32'(sa / sb); lat = 33; end
      5'd21: if (b == 0) r = '1; else begin r = 32'(ua / ub); lat = 33; end
      5'd22: if (b == 0) r = a; else if (ovf) r = '0; else begin r = 32'(sa % sb); lat = 33; end
      5'd23: if (b == 0) r = a; else begin r = 32'(ua % ub); lat = 33; end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic err, output logic zf,
                        output logic nf, output int lat, output int busy);
    int guard = 0;
    @(negedge clk);
    while (!bus.ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.op_i = op; bus.a_i = a; bus.b_i = b;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0; bus.a_i = $urandom; bus.b_i = $urandom;
    lat = 1; busy = 0;
    @(negedge clk);
    while (!bus.valid_o && lat < 100) begin
      if (bus.busy_o) busy++;
      lat++;
      @(negedge clk);
    end
    res = bus.result_o; err = bus.err_o; zf = bus.zero_o; nf = bus.negative_o;
  endtask

  task automatic check_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] xres, input logic xerr,
                          input int xlat);
    logic [31:0] res;
    logic        err, zf, nf;
    int          lat, busy;
    run_op(op, a, b, res, err, zf, nf, lat, busy);
    chk({tag, " result"},   res, xres);
    chk({tag, " err"},      {31'd0, err}, {31'd0, xerr});
    chk({tag, " latency"},  lat, xlat);
    chk({tag, " zero"},     {31'd0, zf}, {31'd0, (xres == 0)});
    chk({tag, " negative"}, {31'd0, nf}, {31'd0, xres[31]});
    chk({tag, " busy"},     busy, (xlat == 33) ? 32 : 0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  legal [18];
    logic [4:0]  rop;
    logic [31:0] ra, rb, xr;
    logic        xe;
    int          xl;
    logic        saw;
    logic [4:0]  ops2 [3];
    logic [31:0] exp2 [3];
    logic        err2 [3];

    vecs[0]  = '{5'b00010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1};
    vecs[1]  = '{5'b00110, 32'd5,         32'd5,         32'h0,         1'b0, 1};
    vecs[2]  = '{5'b00111, 32'h8000_0000, 32'd33,        32'hC000_0000, 1'b0, 1};
    vecs[3]  = '{5'b10001, 32'hFFFF_FFFB, 32'd3,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[4]  = '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[5]  = '{5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
    vecs[6]  = '{5'b10100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{5'b10110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[8]  = '{5'b10101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 1};
    vecs[9]  = '{5'b10111, 32'd7,         32'd0,         32'd7,         1'b0, 1};
    vecs[10] = '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    vecs[11] = '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1};
    vecs[12] = '{5'b01111, 32'd12345,     32'd678,       32'h0,         1'b1, 1};
    vecs[13] = '{5'b01000, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1};
    vecs[14] = '{5'b01001, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1};
    vecs[15] = '{5'b00100, 32'd1,         32'd36,        32'h10,        1'b0, 1};
    vecs[16] = '{5'b10010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[17] = '{5'b10101, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0, 33};
    vecs[18] = '{5'b10111, 32'd10,        32'd3,         32'd1,         1'b0, 33};
    vecs[19] = '{5'b00011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
    vecs[20] = '{5'b00101, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1};
    vecs[21] = '{5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33};

    legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
              5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    ops2  = '{5'b10000, 5'b10101, 5'b00010};
    exp2  = '{32'h0, 32'h0, 32'd9};
    err2  = '{1'b1, 1'b1, 1'b0};

    bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0;
    bus2.valid_i = 1'b0; bus2.ready_i = 1'b1; bus2.op_i = '0; bus2.a_i = '0; bus2.b_i = '0;

    // Reset state
    #12;
    chk("rst valid_o",    {31'd0, bus.valid_o},    32'd0);
    chk("rst result_o",   bus.result_o,            32'd0);
    chk("rst zero_o",     {31'd0, bus.zero_o},     32'd1);
    chk("rst negative_o", {31'd0, bus.negative_o}, 32'd0);
    chk("rst err_o",      {31'd0, bus.err_o},      32'd0);
    chk("rst busy_o",     {31'd0, bus.busy_o},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready_o", {31'd0, bus.ready_o}, 32'd1);

    // Directed vector table
    for (int i = 0; i < NV; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].err, vecs[i].lat);

    // Backpressure on a DIVU result (100/7 = 14)
    @(negedge clk);
    bus.op_i = 5'b10101; bus.a_i = 32'd100; bus.b_i = 32'd7;
    bus.valid_i = 1'b1; bus.ready_i = 1'b0;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    xl = 0;
    @(negedge clk);
    while (!bus.valid_o && xl < 100) begin
      xl++;
      @(negedge clk);
    end
    chk("bp divu valid", {31'd0, bus.valid_o}, 32'd1);
    bus.op_i = 5'b00000; bus.a_i = 32'h0000_F0F0; bus.b_i = 32'h0000_FF00; bus.valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", c),  {31'd0, bus.valid_o}, 32'd1);
      chk($sformatf("bp hold%0d result", c), bus.result_o, 32'd14);
      chk($sformatf("bp hold%0d ready", c),  {31'd0, bus.ready_o}, 32'd0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    chk("bp and valid",  {31'd0, bus.valid_o}, 32'd1);
    chk("bp and result", bus.result_o, 32'h0000_F000);

    // Asynchronous reset 10 cycles into a DIV
    @(negedge clk);
    bus.op_i = 5'b10100; bus.a_i = 32'hFFFF_FF9C; bus.b_i = 32'd7; bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    chk("mid-div busy", {31'd0, bus.busy_o}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy_o",   {31'd0, bus.busy_o},   32'd0);
    chk("async rst valid_o",  {31'd0, bus.valid_o},  32'd0);
    chk("async rst result_o", bus.result_o,          32'd0);
    chk("async rst zero_o",   {31'd0, bus.zero_o},   32'd1);
    chk("async rst err_o",    {31'd0, bus.err_o},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst ready_o", {31'd0, bus.ready_o}, 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) saw = 1'b1;
    end
    chk("no valid after rst", {31'd0, saw}, 32'd0);
    check_op("post rst add", 5'b00010, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // EN_MULDIV = 0 instance
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus2.op_i = ops2[k]; bus2.a_i = 32'd4; bus2.b_i = 32'd5; bus2.valid_i = 1'b1;
      @(posedge clk);
      #1 bus2.valid_i = 1'b0;
      @(negedge clk);
      chk($sformatf("nomd%0d valid", k),  {31'd0, bus2.valid_o}, 32'd1);
      chk($sformatf("nomd%0d err", k),    {31'd0, bus2.err_o},   {31'd0, err2[k]});
      chk($sformatf("nomd%0d result", k), bus2.result_o,         exp2[k]);
    end

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(0, 31));
      else                           rop = legal[$urandom_range(0, 17)];
      ra = pick_val();
      rb = pick_val();
      model(rop, ra, rb, xr, xe, xl);
      check_op($sformatf("rnd%0d op%0d a%0h b%0h", n, rop, ra, rb), rop, ra, rb, xr, xe, xl);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
